mux8_scan_arb: RTL and testbench

- Round-robin scan controller that sits directly upstream of the team's 8:1 4-bit mux.
- Arbitrates among 8 per-channel requests, drives the mux select lines, waits a programmable settle time, then captures the mux output.
- Presents each capture on a valid/ready output port, tagged with its channel number.
- Turns the purely combinational mux into a sequenced, flow-controlled sampler.

---
 rtl/mux8_scan_arb.sv | 123 ++++++++++++
 tb/tb_mux8_scan_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_arb.sv
// Round-robin scan controller for an 8:1 mux: picks a requesting channel, drives sel,
// waits a settle time, captures mux_y and offers it on a valid/ready port.
module mux8_scan_arb #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] mux_y,
  output logic [2:0]       sel,
  output logic [7:0]       grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_ch,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       ch_q, ch_d;
  logic [2:0]       winner;
  logic [2:0]       cand;
  logic             found;

  // First requester strictly after the last-served channel, wrapping 7->0.
  always_comb begin
    winner = last_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cand = last_q + 3'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = winner;
          cnt_d   = SETTLE_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = mux_y;
          ch_d    = sel_q;
          valid_d = 1'b1;
          grant_d = 8'd1 << sel_q;
          last_d  = sel_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 7 so channel 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux8_scan_arb.sv
// Self-checking bench for mux8_scan_arb: vector table, directed corner cases and
// randomized transactions against a round-robin reference model.
module tb_mux8_scan_arb;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;

  logic             clk;
  logic             rst_n;
  logic [7:0]       req;
  logic [WIDTH-1:0] mux_y;
  logic [2:0]       sel;
  logic [7:0]       grant;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_ch;
  logic             busy;

  logic [WIDTH-1:0] chanVal [8];
  int total = 0;
  int passed = 0;
  int modelLast;

  typedef struct {
    logic [7:0] reqVal;
    logic       ready;
    logic [2:0] expSel;
    logic       expValid;
    logic [7:0] expGrant;
    logic [3:0] expData;
    logic [2:0] expCh;
    logic       expBusy;
  } vec_t;

  vec_t vecs [5];

  assign mux_y = chanVal[sel];

  mux8_scan_arb #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mux_y(mux_y), .sel(sel), .grant(grant),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] reqVal, input logic readyVal);
    req       = reqVal;
    out_ready = readyVal;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set bit searching upward from last+1, wrapping.
  function automatic int refPick(input int last, input logic [7:0] r);
    int w = -1;
    for (int k = 1; k <= 8; k++) begin
      if (w < 0 && r[(last + k) % 8]) w = (last + k) % 8;
    end
    return w;
  endfunction

  task automatic applyReset(input int cycles);
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    for (int c = 0; c < cycles; c++) begin
      tick();
      checkOutput("rst_sel", int'(sel), 0);
      checkOutput("rst_grant", int'(grant), 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_data", int'(out_data), 0);
      checkOutput("rst_ch", int'(out_ch), 0);
      checkOutput("rst_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    modelLast = 7;
  endtask

  task automatic waitCapture(output int cycles);
    bit seen = 0;
    cycles = 0;
    while (!seen && cycles < 40) begin
      tick();
      cycles++;
      if (grant != 8'h00) seen = 1;
    end
    if (!seen) cycles = -1;
  endtask

  task automatic checkCapture(input string tag, input int expCh, input int expData);
    checkOutput({tag, "_grant"}, int'(grant), 1 << expCh);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_ch"}, int'(out_ch), expCh);
    checkOutput({tag, "_data"}, int'(out_data), expData);
    checkOutput({tag, "_sel"}, int'(sel), expCh);
  endtask

  task automatic runHeld(input logic [7:0] reqVal, input string tag);
    int cyc;
    int expCh;
    applyStimulus(reqVal, 1'b1);
    expCh = refPick(modelLast, reqVal);
    waitCapture(cyc);
    checkOutput({tag, "_found"}, int'(cyc > 0), 1);
    checkCapture(tag, expCh, int'(chanVal[expCh]));
    modelLast = expCh;
  endtask

  initial begin
    int cyc;
    int expCh;
    logic [WIDTH-1:0] expData;
    logic [7:0] r;
    logic rdy;
    bit done;

    chanVal = '{4'h3, 4'h9, 4'hC, 4'h6, 4'h1, 4'hA, 4'hE, 4'h7};
    vecs[0] = '{8'h20, 1'b1, 3'd5, 1'b0, 8'h00, 4'h0, 3'd0, 1'b1};
    vecs[1] = '{8'h20, 1'b1, 3'd5, 1'b0, 8'h00, 4'h0, 3'd0, 1'b1};
    vecs[2] = '{8'h20, 1'b1, 3'd5, 1'b1, 8'h20, 4'hA, 3'd5, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 4'hA, 3'd5, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 4'hA, 3'd5, 1'b0};

    applyReset(2);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("idle_sel", int'(sel), 0);
      checkOutput("idle_valid", int'(out_valid), 0);
      checkOutput("idle_grant", int'(grant), 0);
      checkOutput("idle_busy", int'(busy), 0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].reqVal, vecs[i].ready);
      tick();
      checkOutput($sformatf("vec%0d_sel", i), int'(sel), int'(vecs[i].expSel));
      checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_ch", i), int'(out_ch), int'(vecs[i].expCh));
      checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].expBusy));
    end

    applyReset(1);
    for (int i = 0; i < 4; i++) runHeld(8'h81, $sformatf("rr81_%0d", i));
    for (int i = 0; i < 8; i++) runHeld(8'hFF, $sformatf("rrFF_%0d", i));
    applyStimulus(8'h00, 1'b1);
    tick();
    checkOutput("rr_end_busy", int'(busy), 0);
    checkOutput("rr_end_valid", int'(out_valid), 0);

    // Backpressure: output must freeze while req toggles underneath.
    applyStimulus(8'h10, 1'b0);
    expCh = refPick(modelLast, 8'h10);
    expData = chanVal[expCh];
    waitCapture(cyc);
    checkOutput("bp_latency", cyc, SETTLE + 2);
    checkCapture("bp_cap", expCh, int'(expData));
    for (int c = 0; c < 10; c++) begin
      req = 8'($urandom);
      tick();
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_data", int'(out_data), int'(expData));
      checkOutput("bp_ch", int'(out_ch), expCh);
      checkOutput("bp_sel", int'(sel), expCh);
      checkOutput("bp_grant", int'(grant), 0);
    end
    applyStimulus(8'h00, 1'b1);
    tick();
    checkOutput("bp_done_valid", int'(out_valid), 0);
    checkOutput("bp_done_busy", int'(busy), 0);
    modelLast = expCh;

    applyStimulus(8'h04, 1'b1);
    tick();
    req = 8'h00;
    waitCapture(cyc);
    checkOutput("wd_latency", cyc, SETTLE + 1);
    checkCapture("wd_cap", 2, int'(chanVal[2]));
    modelLast = 2;
    tick();
    checkOutput("wd_done_busy", int'(busy), 0);

    // Reset while settling on channel 3 must suppress the capture.
    applyStimulus(8'h08, 1'b1);
    tick();
    req = 8'h00;
    checkOutput("rs_sel", int'(sel), 3);
    checkOutput("rs_busy", int'(busy), 1);
    applyReset(2);
    applyStimulus(8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rs_after_grant", int'(grant), 0);
      checkOutput("rs_after_valid", int'(out_valid), 0);
    end
    runHeld(8'hFF, "rs_first");
    checkOutput("rs_first_ch0", int'(out_ch), 0);
    applyStimulus(8'h00, 1'b1);
    tick();

    for (int t = 0; t < 40; t++) begin
      checkOutput("rnd_idle", int'(busy), 0);
      for (int k = 0; k < 8; k++) chanVal[k] = 4'($urandom);
      r = 8'($urandom_range(0, 255));
      if (r == 8'h00) begin
        applyStimulus(8'h00, 1'b0);
        tick();
        checkOutput("rnd_norq_busy", int'(busy), 0);
        checkOutput("rnd_norq_grant", int'(grant), 0);
        continue;
      end
      applyStimulus(r, 1'b0);
      expCh = refPick(modelLast, r);
      expData = chanVal[expCh];
      waitCapture(cyc);
      checkOutput("rnd_latency", cyc, SETTLE + 2);
      checkCapture("rnd_cap", expCh, int'(expData));
      modelLast = expCh;
      done = 0;
      for (int c = 0; c < 50 && !done; c++) begin
        rdy = (c == 49) ? 1'b1 : 1'($urandom_range(0, 1));
        req = rdy ? 8'h00 : 8'($urandom);
        for (int k = 0; k < 8; k++) chanVal[k] = 4'($urandom);
        out_ready = rdy;
        tick();
        if (rdy) begin
          checkOutput("rnd_done_valid", int'(out_valid), 0);
          checkOutput("rnd_done_busy", int'(busy), 0);
          done = 1;
        end else begin
          checkOutput("rnd_hold_valid", int'(out_valid), 1);
          checkOutput("rnd_hold_data", int'(out_data), int'(expData));
          checkOutput("rnd_hold_ch", int'(out_ch), expCh);
          checkOutput("rnd_hold_grant", int'(grant), 0);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
